target_tracker: RTL and testbench
=================================

# target_tracker

Game-logic consumer for the pseudo-random target source. On each snake move step it compares the head cell against the current target. On a hit it signals growth, bumps the score and raises REACHED to pull a fresh target. It then scans the snake body through a read port to reject targets that land on the snake, re-requesting until a clear cell is found. The block sits between the snake position/body store and the target generator, and drives TARGET_VALID to the display path.

## Interface
- H_CELLS, 160: horizontal grid size; any TARGET_H >= H_CELLS is rejected
- V_CELLS, 120: vertical grid size; any TARGET_V >= V_CELLS is rejected
- MAX_LEN, 32: body store depth; AW = $clog2(MAX_LEN)
- SCORE_W, 8: score width
- MAX_RETRY, 8: consecutive rejected targets before the last one is accepted unconditionally
- CLK  in  1  system clock
- RESET  in  1  reset, synchronous, active-high
- TICK  in  1  one-cycle move strobe; HEAD_* are valid in the same cycle
- HEAD_H  in  8  head column
- HEAD_V  in  7  head row
- LENGTH  in  AW+1  body segments currently stored (head included); values above MAX_LEN are clamped to MAX_LEN
- TARGET_H  in  8  target column from the generator
- TARGET_V  in  7  target row from the generator
- BODY_ADDR  out  AW  body store read address
- BODY_H  in  8  segment column; valid 1 cycle after BODY_ADDR
- BODY_V  in  7  segment row; valid 1 cycle after BODY_ADDR
- REACHED  out  1  registered new-target request; the generator updates on its rising edge
- GROW  out  1  one-cycle pulse: snake must grow by one segment
- SCORE  out  SCORE_W  targets eaten, saturating
- TARGET_VALID  out  1  target checked and live; the display shows the target only when this is high
- BUSY  out  1  high in every state except IDLE

## Operation
- All outputs are registered.
- Reset values:
  - state REQ, REACHED=0, GROW=0, SCORE=0, TARGET_VALID=0, BODY_ADDR=0, retry count 0.
  - BUSY=1.
- After RESET deasserts, the block fetches the first target through REQ, with no GROW and no score change.
- States:
  - IDLE: TARGET_VALID=1. On TICK with HEAD_H==TARGET_H and HEAD_V==TARGET_V:
    - GROW=1 for one cycle.
    - SCORE+1, saturating at all-ones.
    - Retry count cleared, TARGET_VALID=0, go to REQ.
    - TICK without a match: no action.
  - REQ: REACHED=1 for exactly 2 cycles, then go to SETTLE.
  - SETTLE: REACHED=0 for 2 cycles so the generator output is stable, then go to SCAN.
  - SCAN:
    - Latch L = min(LENGTH, MAX_LEN) and the target on entry.
    - Issue BODY_ADDR 0..L-1, one per cycle. Compare each returned segment one cycle later.
    - A target is rejected if any segment matches, or if TARGET_H >= H_CELLS or TARGET_V >= V_CELLS.
    - L=0: only the range check is performed; SCAN lasts 1 cycle.
  - After SCAN:
    - If the target is rejected and retry count < MAX_RETRY-1: retry count+1, go to REQ.
    - Otherwise go to IDLE.
- TICK outside IDLE is ignored: no hit detection, no queuing.
- A head on the target cell during REQ/SETTLE/SCAN does not count.
- RESET in any state forces the reset values in the next cycle. A REACHED pulse in progress is truncated.

## Timing
- Hit TICK at cycle t:
  - t+1: GROW=1, SCORE updated, TARGET_VALID=0, REACHED=1.
  - t+2: REACHED=1.
  - t+3, t+4: SETTLE.
  - t+5: SCAN start, BODY_ADDR=0.
  - BODY_ADDR=k at t+5+k. Last compare at t+5+L.
  - TARGET_VALID=1 at t+6+L when the target is accepted.
- Acceptance with L=0: TARGET_VALID=1 at t+6.
- Each retry adds 4+L+1 cycles. Re-entry to REQ occurs the cycle after the last compare.
- Initial fetch: first cycle after RESET low = REQ cycle 1, so TARGET_VALID rises at that cycle +5+L.
- REACHED minimum low time between pulses: 3 cycles (SETTLE plus the first SCAN cycle).
- GROW is exactly 1 cycle and is never reissued on a retry.

## Test plan
- RESET 3 cycles, LENGTH=0 → all outputs at reset values; REACHED high for 2 cycles starting the first cycle after RESET low; TARGET_VALID=1 five cycles after REACHED rises; SCORE=0, no GROW.
- IDLE, target (40,30), head (40,30) with TICK, LENGTH=3, body clear → GROW pulse at t+1, SCORE 0→1, BODY_ADDR 0,1,2 at t+5..t+7, TARGET_VALID=1 at t+9.
- Generator returns (10,10), which matches body segment 2 with LENGTH=4 → second REACHED pulse starts exactly 1 cycle after the last compare; the next clear target is accepted; SCORE incremented once.
- Every returned target collides with the body → exactly MAX_RETRY=8 REACHED pulses, then IDLE with TARGET_VALID=1 on the 8th target.
- SCORE preset to 255 by 255 hits (SCORE_W=8), then one more hit → SCORE stays 255 and GROW still pulses. Also: TICK on target during SCAN → ignored, no GROW.
- RESET asserted during SCAN and during the 2nd REACHED cycle → next cycle REACHED=0, TARGET_VALID=0, SCORE=0, BUSY=1; after release the initial-fetch sequence repeats.

Source files
------------

// File: rtl/target_tracker.sv
// Target hit detection, scoring and body-collision screening of new targets.
// Sits between the snake head/body store and the pseudo-random target source.
module target_tracker #(
    parameter int H_CELLS   = 160,
    parameter int V_CELLS   = 120,
    parameter int MAX_LEN   = 32,
    parameter int SCORE_W   = 8,
    parameter int MAX_RETRY = 8,
    localparam int AW       = $clog2(MAX_LEN)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               i_TICK,
    input  logic [7:0]         i_HEAD_H,
    input  logic [6:0]         i_HEAD_V,
    input  logic [AW:0]        i_LENGTH,
    input  logic [7:0]         i_TARGET_H,
    input  logic [6:0]         i_TARGET_V,
    output logic [AW-1:0]      o_BODY_ADDR,
    input  logic [7:0]         i_BODY_H,
    input  logic [6:0]         i_BODY_V,
    output logic               o_REACHED,
    output logic               o_GROW,
    output logic [SCORE_W-1:0] o_SCORE,
    output logic               o_TARGET_VALID,
    output logic               o_BUSY
);

    localparam int RW = $clog2(MAX_RETRY) + 1;

    localparam logic [8:0]    LIM_H     = 9'(H_CELLS);
    localparam logic [7:0]    LIM_V     = 8'(V_CELLS);
    localparam logic [AW:0]   LEN_MAX   = (AW+1)'(MAX_LEN);
    localparam logic [RW-1:0] RETRY_TOP = RW'(MAX_RETRY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SETTLE,
        S_SCAN
    } state_t;

    state_t          r_state;
    logic            r_phase;
    logic [AW:0]     r_len;
    logic [AW:0]     r_cnt;
    logic [7:0]      r_tgt_h;
    logic [6:0]      r_tgt_v;
    logic            r_hit;
    logic [RW-1:0]   r_retry;

    logic            w_head_hit;
    logic [AW:0]     w_len_clamp;
    logic            w_seg_hit;
    logic            w_out_range;
    logic            w_last;
    logic            w_reject;
    logic            w_retry_ok;
    logic            w_score_max;

    assign w_head_hit  = (i_HEAD_H == i_TARGET_H) && (i_HEAD_V == i_TARGET_V);
    assign w_len_clamp = (i_LENGTH > LEN_MAX) ? LEN_MAX : i_LENGTH;
    // Body data lags the address by one cycle, so scan cycle 0 has nothing to compare.
    assign w_seg_hit   = (r_cnt != '0) &&
                         (i_BODY_H == r_tgt_h) && (i_BODY_V == r_tgt_v);
    assign w_out_range = ({1'b0, r_tgt_h} >= LIM_H) || ({1'b0, r_tgt_v} >= LIM_V);
    assign w_last      = (r_cnt == r_len);
    assign w_reject    = r_hit || w_seg_hit || w_out_range;
    assign w_retry_ok  = (r_retry < RETRY_TOP);
    assign w_score_max = &o_SCORE;

    // Main controller: hit detection, target request, settle wait and body scan.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= S_REQ;
            r_phase        <= 1'b0;
            r_len          <= '0;
            r_cnt          <= '0;
            r_tgt_h        <= '0;
            r_tgt_v        <= '0;
            r_hit          <= 1'b0;
            r_retry        <= '0;
            o_BODY_ADDR    <= '0;
            o_REACHED      <= 1'b0;
            o_GROW         <= 1'b0;
            o_SCORE        <= '0;
            o_TARGET_VALID <= 1'b0;
            o_BUSY         <= 1'b1;
        end else begin
            o_GROW <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_TICK && w_head_hit) begin
                        o_GROW         <= 1'b1;
                        o_SCORE        <= w_score_max ? o_SCORE : o_SCORE + 1'b1;
                        r_retry        <= '0;
                        o_TARGET_VALID <= 1'b0;
                        o_REACHED      <= 1'b1;
                        o_BUSY         <= 1'b1;
                        r_phase        <= 1'b0;
                        r_state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    // REACHED low here only right after reset: start the pulse.
                    if (!o_REACHED) begin
                        o_REACHED <= 1'b1;
                        r_phase   <= 1'b0;
                    end else if (!r_phase) begin
                        r_phase <= 1'b1;
                    end else begin
                        o_REACHED <= 1'b0;
                        r_phase   <= 1'b0;
                        r_state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                    end else begin
                        r_phase     <= 1'b0;
                        r_len       <= w_len_clamp;
                        r_tgt_h     <= i_TARGET_H;
                        r_tgt_v     <= i_TARGET_V;
                        r_cnt       <= '0;
                        r_hit       <= 1'b0;
                        o_BODY_ADDR <= '0;
                        r_state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_last) begin
                        r_cnt       <= '0;
                        o_BODY_ADDR <= '0;
                        if (w_reject && w_retry_ok) begin
                            r_retry   <= r_retry + 1'b1;
                            o_REACHED <= 1'b1;
                            r_phase   <= 1'b0;
                            r_state   <= S_REQ;
                        end else begin
                            o_TARGET_VALID <= 1'b1;
                            o_BUSY         <= 1'b0;
                            r_state        <= S_IDLE;
                        end
                    end else begin
                        r_hit <= r_hit || w_seg_hit;
                        r_cnt <= r_cnt + 1'b1;
                        if ((r_cnt + 1'b1) < r_len) begin
                            o_BODY_ADDR <= o_BODY_ADDR + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_target_tracker.sv
// Directed bench for target_tracker: vector table for a plain hit,
// hand sequences for retries, range rejection, saturation and resets.
module tb_target_tracker;

    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          tick = 1'b0;
    logic [7:0]    head_h = '0;
    logic [6:0]    head_v = '0;
    logic [AW:0]   length = '0;
    logic [7:0]    tgt_h = '0;
    logic [6:0]    tgt_v = '0;
    logic [AW-1:0] body_addr;
    logic [7:0]    body_h = '0;
    logic [6:0]    body_v = '0;
    logic          reached;
    logic          grow;
    logic [7:0]    score;
    logic          tv;
    logic          busy;

    logic [7:0]    mem_h [32];
    logic [6:0]    mem_v [32];
    logic [14:0]   gen_q [$];
    int            rises [$];

    int checks = 0;
    int failures = 0;

    target_tracker dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .i_TICK        (tick),
        .i_HEAD_H      (head_h),
        .i_HEAD_V      (head_v),
        .i_LENGTH      (length),
        .i_TARGET_H    (tgt_h),
        .i_TARGET_V    (tgt_v),
        .o_BODY_ADDR   (body_addr),
        .i_BODY_H      (body_h),
        .i_BODY_V      (body_v),
        .o_REACHED     (reached),
        .o_GROW        (grow),
        .o_SCORE       (score),
        .o_TARGET_VALID(tv),
        .o_BUSY        (busy)
    );

    always #5 CLK = ~CLK;

    // Body store with one cycle of read latency.
    always @(posedge CLK) begin
        body_h <= mem_h[body_addr];
        body_v <= mem_v[body_addr];
    end

    typedef struct {
        bit         tick;
        logic [7:0] hh;
        logic [6:0] hv;
        bit         reached;
        bit         grow;
        bit         tv;
        bit         busy;
        int         score;
        int         addr;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Called in the first cycle with RESET low; L must be 0.
    task automatic initial_fetch(input string tag);
        bit exp_r [6];
        exp_r = '{1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("%s_reached_c%0d", tag, i + 1), reached, exp_r[i]);
            chk($sformatf("%s_tv_c%0d", tag, i + 1), tv, (i == 5));
            chk($sformatf("%s_grow_c%0d", tag, i + 1), grow, 0);
        end
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_score"}, score, 0);
    endtask

    // Optional hit, then run until TARGET_VALID with a generator model
    // that loads the next queued target on each REACHED rise.
    task automatic run(input bit hit, output int tv_at, output int pulses, output int grows);
        bit prev;
        pulses = 0;
        grows = 0;
        tv_at = -1;
        rises.delete();
        prev = reached;
        if (hit) begin
            tick = 1'b1;
            head_h = tgt_h;
            head_v = tgt_v;
        end
        for (int c = 1; c <= 400; c++) begin
            step();
            tick = 1'b0;
            if (grow) grows++;
            if (reached && !prev) begin
                pulses++;
                rises.push_back(c);
                if (gen_q.size() > 0) {tgt_h, tgt_v} = gen_q.pop_front();
            end
            prev = reached;
            if (tv) begin
                tv_at = c;
                break;
            end
        end
    endtask

    initial begin
        int tv_at, pulses, grows, bad, guard;

        for (int i = 0; i < 32; i++) begin
            mem_h[i] = 8'd0;
            mem_v[i] = 7'd0;
        end
        mem_h[0] = 8'd5;  mem_v[0] = 7'd5;
        mem_h[1] = 8'd6;  mem_v[1] = 7'd5;
        mem_h[2] = 8'd10; mem_v[2] = 7'd10;
        mem_h[3] = 8'd11; mem_v[3] = 7'd10;

        // Reset state
        RESET = 1'b1;
        tgt_h = 8'd40;
        tgt_v = 7'd30;
        repeat (3) step();
        chk("rst_reached", reached, 0);
        chk("rst_grow", grow, 0);
        chk("rst_score", score, 0);
        chk("rst_tv", tv, 0);
        chk("rst_addr", body_addr, 0);
        chk("rst_busy", busy, 1);
        RESET = 1'b0;
        initial_fetch("init");

        // Idle tick with no match does nothing
        tick = 1'b1;
        head_h = 8'd0;
        head_v = 7'd0;
        step();
        tick = 1'b0;
        step();
        chk("miss_grow", grow, 0);
        chk("miss_busy", busy, 0);
        chk("miss_tv", tv, 1);

        // Plain hit, L=3, clear body; extra tick during SCAN is ignored
        length = 6'd3;
        tbl[0] = '{1, 8'd40, 7'd30, 1, 1, 0, 1, 1, 0};
        tbl[1] = '{0, 8'd40, 7'd30, 1, 0, 0, 1, 1, 0};
        tbl[2] = '{0, 8'd40, 7'd30, 0, 0, 0, 1, 1, 0};
        tbl[3] = '{0, 8'd40, 7'd30, 0, 0, 0, 1, 1, 0};
        tbl[4] = '{0, 8'd40, 7'd30, 0, 0, 0, 1, 1, 0};
        tbl[5] = '{1, 8'd40, 7'd30, 0, 0, 0, 1, 1, 1};
        tbl[6] = '{0, 8'd40, 7'd30, 0, 0, 0, 1, 1, 2};
        tbl[7] = '{0, 8'd40, 7'd30, 0, 0, 0, 1, 1, -1};
        tbl[8] = '{0, 8'd40, 7'd30, 0, 0, 1, 0, 1, -1};
        for (int i = 0; i < 9; i++) begin
            tick = tbl[i].tick;
            head_h = tbl[i].hh;
            head_v = tbl[i].hv;
            step();
            chk($sformatf("vec%0d_reached", i), reached, tbl[i].reached);
            chk($sformatf("vec%0d_grow", i), grow, tbl[i].grow);
            chk($sformatf("vec%0d_tv", i), tv, tbl[i].tv);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("vec%0d_score", i), score, tbl[i].score);
            if (tbl[i].addr >= 0)
                chk($sformatf("vec%0d_addr", i), body_addr, tbl[i].addr);
        end
        tick = 1'b0;

        // Collision with segment 2, then a clear target
        length = 6'd4;
        gen_q = '{{8'd10, 7'd10}, {8'd20, 7'd20}};
        run(1, tv_at, pulses, grows);
        chk("coll_pulses", pulses, 2);
        chk("coll_rise2", (rises.size() > 1) ? rises[1] : -1, 10);
        chk("coll_tv_at", tv_at, 19);
        chk("coll_grows", grows, 1);
        chk("coll_score", score, 2);

        // Every target collides: accepted after MAX_RETRY pulses
        gen_q.delete();
        for (int i = 0; i < 8; i++) gen_q.push_back({8'd10, 7'd10});
        run(1, tv_at, pulses, grows);
        chk("allcoll_pulses", pulses, 8);
        chk("allcoll_tv_at", tv_at, 73);
        chk("allcoll_grows", grows, 1);
        chk("allcoll_score", score, 3);
        chk("allcoll_busy", busy, 0);

        // Range boundaries with L=0
        length = 6'd0;
        gen_q = '{{8'd160, 7'd0}, {8'd0, 7'd120}, {8'd159, 7'd119}};
        run(1, tv_at, pulses, grows);
        chk("range_pulses", pulses, 3);
        chk("range_rise3", (rises.size() > 2) ? rises[2] : -1, 11);
        chk("range_tv_at", tv_at, 16);
        chk("range_score", score, 4);

        // Drive the score to saturation
        bad = 0;
        guard = 0;
        while (score != 8'd255 && guard < 300) begin
            run(1, tv_at, pulses, grows);
            if (tv_at != 6 || grows != 1) bad++;
            guard++;
        end
        chk("sat_loop_bad", bad, 0);
        chk("sat_score", score, 255);
        run(1, tv_at, pulses, grows);
        chk("sat_grows", grows, 1);
        chk("sat_score_hold", score, 255);
        chk("sat_tv_at", tv_at, 6);

        // Reset during SCAN
        tick = 1'b1;
        head_h = tgt_h;
        head_v = tgt_v;
        step();
        tick = 1'b0;
        repeat (4) step();
        chk("scan_busy", busy, 1);
        RESET = 1'b1;
        step();
        chk("rscan_reached", reached, 0);
        chk("rscan_tv", tv, 0);
        chk("rscan_score", score, 0);
        chk("rscan_busy", busy, 1);
        RESET = 1'b0;
        initial_fetch("rscan");

        // Reset during the second REACHED cycle
        tick = 1'b1;
        head_h = tgt_h;
        head_v = tgt_v;
        step();
        tick = 1'b0;
        chk("rreq_score1", score, 1);
        step();
        chk("rreq_reached2", reached, 1);
        RESET = 1'b1;
        step();
        chk("rreq_reached", reached, 0);
        chk("rreq_tv", tv, 0);
        chk("rreq_score", score, 0);
        chk("rreq_busy", busy, 1);
        RESET = 1'b0;
        initial_fetch("rreq");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
